// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte stream into instruction memory.
// It packs bytes little-endian into 32-bit words, holds the core in reset while
// loading, and hands the imem address to the core once a load has completed.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum byte.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int IMEM_DEPTH      = 1024,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_start,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  input  logic [IMEM_ADDR_WIDTH-1:0] core_addr,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_we,
  output logic [31:0]                imem_wdata,
  output logic                       core_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA,
`ifdef IMEM_LOAD_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(IMEM_DEPTH);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_len_lo;
  logic [23:0] r_shift;        // bytes 0..2 of the word being assembled
  logic [1:0]  r_byte_cnt;     // byte position within the current word
  logic [15:0] r_words_left;
  logic [15:0] r_word_idx;     // next imem word to be written
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_core_rst_n;
  logic        r_done;
  logic        r_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_busy;
  logic        w_start;
  logic        w_xfer;
  logic        w_last_byte;
  logic        w_word_end;
  logic [15:0] w_len;
  logic        w_idx_unused;

  assign w_busy      = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA)
`ifdef IMEM_LOAD_CHECKSUM_EN
                       || (r_state == S_CSUM)
`endif
                       ;
  assign w_start     = load_start && !w_busy;
  assign w_xfer      = rx_valid && w_busy;
  assign w_len       = {rx_data, r_len_lo};
  assign w_word_end  = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
  assign w_last_byte = w_word_end && (r_words_left == 16'd1);

  // Next-state decode for the load sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (load_start) w_state_nxt = S_LEN0;
      S_LEN0: if (w_xfer) w_state_nxt = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len == 16'd0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end else if ({1'b0, w_len} > LP_DEPTH) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_last_byte) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CSUM: if (w_xfer) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERROR;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Counters, write strobe and registered status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_byte_cnt   <= 2'd0;
      r_words_left <= 16'd0;
      r_word_idx   <= 16'd0;
      r_we         <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_we         <= 1'b0;
      r_core_rst_n <= (r_state == S_DONE) && !w_start;
      r_done       <= (r_state == S_DONE) && !w_start;
      r_err        <= (r_state == S_ERROR) && !w_start;
      if (w_start) begin
        r_byte_cnt   <= 2'd0;
        r_words_left <= 16'd0;
        r_word_idx   <= 16'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        r_csum       <= 8'd0;
`endif
      end else begin
        // Index advances after the strobe cycle so imem_addr holds k during the write
        if (r_we) r_word_idx <= r_word_idx + 16'd1;
        if (w_xfer && (r_state == S_LEN1)) r_words_left <= w_len;
        if (w_xfer && (r_state == S_DATA)) begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
          r_csum     <= r_csum ^ rx_data;
`endif
          if (r_byte_cnt == 2'd3) begin
            r_we         <= 1'b1;
            r_words_left <= r_words_left - 16'd1;
          end
        end
      end
    end
  end

  // Byte capture: length low byte and partial word assembly
  always_ff @(posedge clk) begin
    if (w_xfer && (r_state == S_LEN0)) r_len_lo <= rx_data;
    if (w_xfer && (r_state == S_DATA)) begin
      case (r_byte_cnt)
        2'd0:    r_shift[7:0]   <= rx_data;
        2'd1:    r_shift[15:8]  <= rx_data;
        2'd2:    r_shift[23:16] <= rx_data;
        default: r_shift        <= r_shift;
      endcase
    end
  end

  // Write data register: completed word lands on the fourth byte
  always_ff @(posedge clk) begin
    if (!reset_n)        r_wdata <= 32'd0;
    else if (w_word_end) r_wdata <= {rx_data, r_shift};
  end

  // The last word's strobe lands in the first DONE cycle, so keep the loader
  // address on the bus until that write retires.
  assign imem_addr    = ((r_state == S_DONE) && !r_we) ? core_addr
                                                       : r_word_idx[IMEM_ADDR_WIDTH-1:0];
  assign w_idx_unused = ^r_word_idx[15:IMEM_ADDR_WIDTH];
  assign rx_ready     = w_busy;
  assign busy         = w_busy;
  assign imem_we      = r_we;
  assign imem_wdata   = r_wdata;
  assign core_rst_n   = r_core_rst_n;
  assign done         = r_done;
  assign err          = r_err;

endmodule
